uart_msg_assembler: RTL and testbench

//  Packs the byte stream from the UART receiver into one MSG_WIDTH-bit command message.

---
 rtl/uart_msg_pkg.sv | 33 +++
 rtl/uart_msg_assembler_if.sv | 22 ++
 rtl/msg_timeout_timer.sv | 38 +++
 rtl/uart_msg_assembler.sv | 123 ++++++++++++
 tb/tb_uart_msg_assembler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_msg_pkg.sv
// Shared definitions for the UART command message path: message width, field layout,
// header codes and the assembler state type.
package uart_msg_pkg;

    localparam int unsigned UART_MSG_WIDTH = 64;
    localparam int unsigned HDR_WIDTH      = 8;
    localparam int unsigned PAYLOAD_WIDTH  = UART_MSG_WIDTH - HDR_WIDTH;

    localparam int unsigned HDR_MSB     = UART_MSG_WIDTH - 1;
    localparam int unsigned HDR_LSB     = PAYLOAD_WIDTH;
    localparam int unsigned PAYLOAD_MSB = PAYLOAD_WIDTH - 1;
    localparam int unsigned PAYLOAD_LSB = 0;

    typedef enum logic [HDR_WIDTH-1:0] {
        HdrNop   = 8'h00,
        HdrRead  = 8'h01,
        HdrWrite = 8'h02,
        HdrDelay = 8'h08
    } msg_hdr_e;

    typedef enum logic [0:0] {
        StIdle,
        StAssemble
    } asm_state_e;

    function automatic logic [UART_MSG_WIDTH-1:0] make_msg(
        input logic [HDR_WIDTH-1:0]     hdr,
        input logic [PAYLOAD_WIDTH-1:0] payload
    );
        return {hdr, payload};
    endfunction

endpackage

// File: rtl/uart_msg_assembler_if.sv
// Output handshake between the message assembler (master) and the command decoder (slave).
interface uart_msg_assembler_if #(
    parameter int unsigned MSG_WIDTH = 64
) ();

    logic [MSG_WIDTH-1:0] msg_data;
    logic                 msg_valid;
    logic                 msg_ready;

    modport master (
        output msg_data,
        output msg_valid,
        input  msg_ready
    );

    modport slave (
        input  msg_data,
        input  msg_valid,
        output msg_ready
    );

endinterface

// File: rtl/msg_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles up to TIMEOUT_CLKS and saturates.
module msg_timeout_timer #(
    parameter int unsigned TIMEOUT_CLKS = 200_000
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CntW-1:0] Limit   = CntW'(TIMEOUT_CLKS);
    localparam logic [CntW-1:0] LimitM1 = CntW'(TIMEOUT_CLKS - 1);

    logic [CntW-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != Limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Asserted on the edge at which the count reaches the limit.
    assign expired = enable && !clear && (count_q >= LimitM1);

endmodule

// File: rtl/uart_msg_assembler.sv
// Packs LSB-first UART bytes into one message, drops partials on timeout or framing error,
// and holds the finished message under a valid/ready handshake.
module uart_msg_assembler
    import uart_msg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MSG_WIDTH    = UART_MSG_WIDTH,
    parameter int unsigned TIMEOUT_CLKS = 200_000
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_frame_err,
    uart_msg_assembler_if.master  msg,
    output logic                  overflow,
    output logic                  resync,
    input  logic                  overflow_clr
);

    localparam int unsigned WORDS = MSG_WIDTH / DATA_WIDTH;
    localparam int unsigned CntW  = $clog2(WORDS);
    localparam logic [CntW-1:0] LastIdx = CntW'(WORDS - 1);

    asm_state_e           state_q, state_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [MSG_WIDTH-1:0] shift_q, shift_d;
    logic [MSG_WIDTH-1:0] msg_data_q, msg_data_d;
    logic                 msg_valid_q, msg_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 resync_q, resync_d;

    logic timer_clear, timer_enable, timer_expired;
    logic timeout, complete, accept;

    assign timer_clear  = rx_valid || rx_frame_err || (state_q == StIdle);
    assign timer_enable = (state_q == StAssemble);

    msg_timeout_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign timeout  = timer_expired;
    assign complete = rx_valid && !rx_frame_err && (state_q == StAssemble) &&
                      (count_q == LastIdx);
    assign accept   = msg_valid_q && msg.msg_ready;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            shift_q     <= '0;
            msg_data_q  <= '0;
            msg_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            resync_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            msg_data_q  <= msg_data_d;
            msg_valid_q <= msg_valid_d;
            overflow_q  <= overflow_d;
            resync_q    <= resync_d;
        end
    end

    // Count is always zero in StIdle, so it doubles as the byte slot index in both states.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        if (rx_frame_err) begin
            state_d = StIdle;
            count_d = '0;
        end else if (rx_valid) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                if (count_q == CntW'(i)) begin
                    shift_d[i*DATA_WIDTH +: DATA_WIDTH] = rx_data;
                end
            end
            if (count_q == LastIdx) begin
                state_d = StIdle;
                count_d = '0;
            end else begin
                state_d = StAssemble;
                count_d = count_q + 1'b1;
            end
        end else if (timeout) begin
            state_d = StIdle;
            count_d = '0;
        end
    end

    always_comb begin
        resync_d    = (rx_frame_err && ((count_q != '0) || rx_valid)) || timeout;
        msg_data_d  = msg_data_q;
        msg_valid_d = msg_valid_q;
        overflow_d  = overflow_q && !overflow_clr;
        if (complete) begin
            if (!msg_valid_q || msg.msg_ready) begin
                msg_data_d  = shift_d;
                msg_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (accept) begin
            msg_valid_d = 1'b0;
        end
    end

    assign msg.msg_data  = msg_data_q;
    assign msg.msg_valid = msg_valid_q;
    assign overflow      = overflow_q;
    assign resync        = resync_q;

endmodule

// File: tb/tb_uart_msg_assembler.sv
// Directed bench for uart_msg_assembler with a short inter-byte timeout.
module tb_uart_msg_assembler;
    import uart_msg_pkg::*;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       overflow;
    logic       resync;
    logic       overflow_clr;

    int total = 0;
    int bad   = 0;
    int resync_cnt = 0;
    int accept_cnt = 0;

    uart_msg_assembler_if #(.MSG_WIDTH(64)) msg_if ();

    uart_msg_assembler #(
        .DATA_WIDTH   (8),
        .MSG_WIDTH    (64),
        .TIMEOUT_CLKS (50)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .msg          (msg_if),
        .overflow     (overflow),
        .resync       (resync),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resync === 1'b1) resync_cnt++;
        if (n_reset && msg_if.msg_valid === 1'b1 && msg_if.msg_ready === 1'b1) accept_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Sends bytes lo..hi-1 of m, 10 clks apart; returns on the negedge after the last byte.
    task automatic send_bytes(input logic [63:0] m, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            send_byte(m[i*8 +: 8]);
            if (i != hi - 1) idle(9);
        end
    endtask

    initial begin
        logic [63:0] m_a, m_b;
        int r0, a0;

        n_reset      = 1'b0;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        overflow_clr = 1'b0;
        msg_if.msg_ready = 1'b0;
        idle(2);
        check("rst_valid", {63'd0, msg_if.msg_valid}, 64'd0);
        check("rst_data", msg_if.msg_data, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_resync", {63'd0, resync}, 64'd0);
        n_reset = 1'b1;
        idle(2);

        // 1: basic message, accepted immediately
        msg_if.msg_ready = 1'b1;
        a0 = accept_cnt;
        send_bytes(64'h0807060504030201, 0, 8);
        check("t1_valid", {63'd0, msg_if.msg_valid}, 64'd1);
        check("t1_data", msg_if.msg_data, make_msg(HdrDelay, 56'h07060504030201));
        idle(1);
        check("t1_valid_low", {63'd0, msg_if.msg_valid}, 64'd0);
        check("t1_accepts", 64'(accept_cnt - a0), 64'd1);
        idle(9);

        // 2: partial message times out, then a clean message
        r0 = resync_cnt;
        send_bytes(64'h0000000000CCBBAA, 0, 3);
        idle(49);
        check("t2_no_early_resync", {63'd0, resync}, 64'd0);
        idle(1);
        check("t2_resync_at_50", {63'd0, resync}, 64'd1);
        idle(1);
        check("t2_resync_pulse_end", {63'd0, resync}, 64'd0);
        idle(9);
        check("t2_resync_count", 64'(resync_cnt - r0), 64'd1);
        a0 = accept_cnt;
        send_bytes(64'hAAAAAAAAAAAAAAAA, 0, 8);
        check("t2_valid", {63'd0, msg_if.msg_valid}, 64'd1);
        check("t2_data", msg_if.msg_data, 64'hAAAAAAAAAAAAAAAA);
        idle(2);
        check("t2_one_msg", 64'(accept_cnt - a0), 64'd1);
        idle(8);

        // 3: overflow while held, then clear
        msg_if.msg_ready = 1'b0;
        m_a = 64'h0123456789ABCDEF;
        m_b = 64'hFEDCBA9876543210;
        send_bytes(m_a, 0, 8);
        check("t3_first_valid", {63'd0, msg_if.msg_valid}, 64'd1);
        check("t3_no_overflow_yet", {63'd0, overflow}, 64'd0);
        idle(9);
        send_bytes(m_b, 0, 8);
        check("t3_overflow", {63'd0, overflow}, 64'd1);
        check("t3_held_data", msg_if.msg_data, m_a);
        check("t3_still_valid", {63'd0, msg_if.msg_valid}, 64'd1);
        idle(3);
        check("t3_overflow_sticky", {63'd0, overflow}, 64'd1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("t3_overflow_clr", {63'd0, overflow}, 64'd0);
        check("t3_data_after_clr", msg_if.msg_data, m_a);
        msg_if.msg_ready = 1'b1;
        idle(1);
        msg_if.msg_ready = 1'b0;
        check("t3_drained", {63'd0, msg_if.msg_valid}, 64'd0);
        idle(9);

        // 4: framing error on byte 5 discards the partial message
        r0 = resync_cnt;
        send_bytes(64'h0000000024232221, 0, 4);
        idle(9);
        rx_data      = 8'h25;
        rx_valid     = 1'b1;
        rx_frame_err = 1'b1;
        @(negedge clk);
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        check("t4_resync", {63'd0, resync}, 64'd1);
        check("t4_no_msg", {63'd0, msg_if.msg_valid}, 64'd0);
        idle(9);
        send_bytes(64'h8877665544332211, 0, 8);
        check("t4_valid", {63'd0, msg_if.msg_valid}, 64'd1);
        check("t4_data", msg_if.msg_data, 64'h8877665544332211);
        check("t4_resync_count", 64'(resync_cnt - r0), 64'd1);
        msg_if.msg_ready = 1'b1;
        idle(1);
        msg_if.msg_ready = 1'b0;
        idle(9);

        // 5: completion on the same edge as accept of the held message
        m_a = 64'hA8A7A6A5A4A3A2A1;
        m_b = 64'h5857565554535251;
        send_bytes(m_a, 0, 8);
        idle(9);
        send_bytes(m_b, 0, 7);
        idle(9);
        rx_data  = m_b[63:56];
        rx_valid = 1'b1;
        msg_if.msg_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        msg_if.msg_ready = 1'b0;
        check("t5_valid", {63'd0, msg_if.msg_valid}, 64'd1);
        check("t5_data", msg_if.msg_data, m_b);
        check("t5_overflow", {63'd0, overflow}, 64'd0);
        idle(9);

        // 6: reset mid-message clears everything, including a pending overflow
        send_bytes(64'hDEADBEEFCAFEF00D, 0, 8);
        check("t6_pre_overflow", {63'd0, overflow}, 64'd1);
        idle(9);
        send_bytes(64'h00000000B4B3B2B1, 0, 4);
        idle(3);
        r0 = resync_cnt;
        n_reset = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", {63'd0, msg_if.msg_valid}, 64'd0);
        check("t6_rst_data", msg_if.msg_data, 64'd0);
        check("t6_rst_overflow", {63'd0, overflow}, 64'd0);
        check("t6_rst_resync", {63'd0, resync}, 64'd0);
        @(negedge clk);
        n_reset = 1'b1;
        idle(9);
        send_bytes(64'hC8C7C6C5C4C3C2C1, 0, 8);
        check("t6_valid", {63'd0, msg_if.msg_valid}, 64'd1);
        check("t6_data", msg_if.msg_data, 64'hC8C7C6C5C4C3C2C1);
        check("t6_overflow", {63'd0, overflow}, 64'd0);
        idle(60);
        check("t6_no_resync", 64'(resync_cnt - r0), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
